// File: rtl/pitch_sdram_arbiter.sv
// Two-client round-robin arbiter onto a single Avalon-MM SDRAM master port.
// One single-word transaction in flight at a time; reads are bounded by TIMEOUT.
module pitch_sdram_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        c0_read,
    input  logic        c0_write,
    input  logic [22:0] c0_addr,
    input  logic [31:0] c0_writedata,
    output logic [31:0] c0_readdata,
    output logic        c0_finished,
    input  logic        c1_read,
    input  logic        c1_write,
    input  logic [22:0] c1_addr,
    input  logic [31:0] c1_writedata,
    output logic [31:0] c1_readdata,
    output logic        c1_finished,
    output logic        o_timeout,
    output logic [22:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          ptr_q, ptr_d;
    logic          op_q, op_d;
    logic [22:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
    logic [31:0]   rd0_q, rd0_d;
    logic [31:0]   rd1_q, rd1_d;

    logic          req0, req1, sel;
    logic [CW-1:0] cnt_inc;

    assign req0    = c0_read | c0_write;
    assign req1    = c1_read | c1_write;
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            ptr_q   <= 1'b0;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        sel     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // ptr_q names the client that lost (or was not granted) last time
                    sel     = (req0 & req1) ? ptr_q : req1;
                    gnt_d   = sel;
                    ptr_d   = ~sel;
                    op_d    = sel ? c1_write : c0_write;
                    addr_d  = sel ? c1_addr : c0_addr;
                    wdata_d = sel ? c1_writedata : c0_writedata;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest)
                    state_d = op_q ? DONE : WAIT_DATA;
            end
            WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    if (gnt_q) rd1_d = avm_readdata;
                    else       rd0_d = avm_readdata;
                    state_d = DONE;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    if (gnt_q) rd1_d = '0;
                    else       rd0_d = '0;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign avm_read      = (state_q == ISSUE) & ~op_q;
    assign avm_write     = (state_q == ISSUE) &  op_q;
    assign avm_address   = addr_q;
    assign avm_writedata = wdata_q;
    assign c0_finished   = (state_q == DONE) & ~gnt_q;
    assign c1_finished   = (state_q == DONE) &  gnt_q;
    assign o_timeout     = to_q;
    assign c0_readdata   = rd0_q;
    assign c1_readdata   = rd1_q;

endmodule

// File: doc/pitch_sdram_arbiter.md
# pitch_sdram_arbiter

Two-client SDRAM access arbiter directly downstream of the pitch-processing core. Accepts single-word read/write requests on a level request / one-cycle `finished` handshake from client 0 (pitch core) and client 1 (audio record/playback path). Serialises them round-robin onto one Avalon-MM master port of the SDRAM controller, which supports waitrequest and readdatavalid. Exactly one transaction is in flight at a time.

## Interface
- TIMEOUT, 1023: maximum cycles spent in WAIT_DATA before a read is force-completed.

- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- c0_read / c1_read  in  1  client read request, level
- c0_write / c1_write  in  1  client write request, level
- c0_addr / c1_addr  in  23  word address
- c0_writedata / c1_writedata  in  32  write data
- c0_readdata / c1_readdata  out  32  registered read result per client
- c0_finished / c1_finished  out  1  one-cycle completion pulse
- o_timeout  out  1  one-cycle pulse when a read is force-completed
- avm_address  out  23  SDRAM word address
- avm_read / avm_write  out  1  Avalon command strobes
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  controller stall
- avm_readdatavalid  in  1  read data valid

## Operation
- Client request is `cN_read | cN_write`. If both are high, the request is a write.
- Address and data must stay stable while the request is high. They are latched at grant, so later changes are ignored.
- A request still high in the cycle after `cN_finished` is a new request.
- FSM states: IDLE, ISSUE, WAIT_DATA, DONE.
- IDLE:
  - If any request is present, grant one client and latch client id, op, addr and writedata. Go to ISSUE.
  - Round-robin: the client not granted last wins when both request. After reset, client 0 has priority.
- ISSUE:
  - `avm_read` or `avm_write` is high, driven from registers, together with the latched addr and data.
  - Stay while `avm_waitrequest`=1.
  - When `avm_waitrequest`=0: a write goes to DONE; a read goes to WAIT_DATA.
- WAIT_DATA:
  - Command strobes are low.
  - When `avm_readdatavalid`=1, store `avm_readdata` into the granted client's readdata register and go to DONE.
  - A cycle counter runs in this state. When it reaches TIMEOUT, store 0 into the client's readdata, pulse `o_timeout`, and go to DONE.
  - A `readdatavalid` arriving in any other state is ignored.
- DONE:
  - The granted client's `finished` is 1 for exactly this cycle. Then go to IDLE.
  - `cN_readdata` holds its value until that client's next read completes. Writes never change it.
- Mid-operation reset: all state returns to IDLE immediately. Any in-flight Avalon transaction is abandoned and no `finished` is produced.
- Reset values: every output is 0, every readdata register is 0, the grant pointer selects client 0, and the counter is 0.

## Timing
- Write, zero waitrequest: request sampled in IDLE at cycle 0, `avm_write` high in cycle 1, `finished` in cycle 2. Latency is 2 cycles.
- Read, zero waitrequest, readdatavalid k≥1 cycles after accept: `finished` at cycle 2+k. Readdata is valid in the same cycle as `finished`.
- Each waitrequest cycle adds one cycle of latency.
- Minimum request-to-request spacing is 3 cycles for writes; IDLE is always visited.
- The losing client's request waits and is granted in the next IDLE in which it is still asserted.
- `o_timeout` and `finished` are asserted in the same DONE cycle.

## Test plan
- Single c0 write, addr 0x000010, data 0xDEADBEEF, waitrequest low -> `avm_write`=1 with that addr/data for exactly 1 cycle; `c0_finished` exactly 2 cycles after request.
- c1 read at addr 0x7FFFFF, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with 0x12345678 -> `c1_readdata`=0x12345678 when `c1_finished` pulses; `c0_readdata` unchanged.
- c0 and c1 request simultaneously from reset, both held continuously -> grants alternate c0, c1, c0; no `finished` pulse ever goes to the wrong client.
- Read with readdatavalid never asserted, TIMEOUT=1023 -> `o_timeout` and `c0_finished` in the same cycle; `c0_readdata`=0; FSM returns to IDLE.
- Assert `i_rst` during ISSUE with waitrequest high -> `avm_read`/`avm_write` drop asynchronously, all outputs 0, no `finished`; a new request after reset completes normally.
- c0_read and c0_write both high -> write performed; `c0_readdata` unchanged.
